// File: rtl/commit_trace_tx.sv
// rtl/commit_trace_tx.sv - commit trace record FIFO with cycle/commit/drop counters
// Optional no-commit watchdog built when OOOP_TRACE_WATCHDOG_EN is defined.
module commit_trace_tx #(
    parameter int DEPTH           = 8,
    parameter int PREG_W          = 6,
    parameter int STALL_THRESHOLD = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_v,
    input  logic [31:0]       commit_pc,
    input  logic              commit_rd_used,
    input  logic [4:0]        commit_rd,
    input  logic [PREG_W-1:0] commit_prd,
    input  logic [31:0]       commit_data,
    output logic              tr_valid,
    input  logic              tr_ready,
    output logic [31:0]       tr_seq,
    output logic [31:0]       tr_cycle,
    output logic [31:0]       tr_pc,
    output logic [4:0]        tr_rd,
    output logic              tr_rd_used,
    output logic [PREG_W-1:0] tr_prd,
    output logic [31:0]       tr_data,
    output logic [31:0]       cycle_count,
    output logic [31:0]       commit_count,
    output logic [15:0]       drop_count,
    output logic              overflow,
    output logic              hang
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0]       seq;
        logic [31:0]       cyc;
        logic [31:0]       pc;
        logic [4:0]        rd;
        logic              rd_used;
        logic [PREG_W-1:0] prd;
        logic [31:0]       data;
    } rec_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STALL_THRESHOLD < 1) begin : g_bad_param
        $error("commit_trace_tx: illegal DEPTH or STALL_THRESHOLD");
    end

    rec_t        mem [DEPTH];
    rec_t        head_rec;
    rec_t        new_rec;
    logic [AW:0] head;
    logic [AW:0] tail;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push_ok;
    logic        drop;

    assign empty   = (head == tail);
    assign full    = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);
    assign pop     = tr_valid && tr_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = commit_v && (!full || pop);
    assign drop    = commit_v && full && !pop;

    always_comb begin
        new_rec         = '0;
        new_rec.seq     = commit_count;
        new_rec.cyc     = cycle_count;
        new_rec.pc      = commit_pc;
        new_rec.rd      = commit_rd;
        new_rec.rd_used = commit_rd_used;
        new_rec.prd     = commit_prd;
        new_rec.data    = (commit_rd_used && commit_rd != 5'd0) ? commit_data : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[tail[AW-1:0]] <= new_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            cycle_count  <= '0;
            commit_count <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (commit_v) begin
                commit_count <= commit_count + 32'd1;
            end
            if (push_ok) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    // Stale memory is masked while empty so fields read zero after reset.
    assign head_rec   = empty ? '0 : mem[head[AW-1:0]];
    assign tr_valid   = !empty;
    assign tr_seq     = head_rec.seq;
    assign tr_cycle   = head_rec.cyc;
    assign tr_pc      = head_rec.pc;
    assign tr_rd      = head_rec.rd;
    assign tr_rd_used = head_rec.rd_used;
    assign tr_prd     = head_rec.prd;
    assign tr_data    = head_rec.data;

`ifdef OOOP_TRACE_WATCHDOG_EN
    logic [31:0] stall_ctr;
    logic        hang_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_ctr <= '0;
            hang_r    <= 1'b0;
        end else begin
            if (commit_v) begin
                stall_ctr <= '0;
            end else if (stall_ctr != 32'hFFFF_FFFF) begin
                stall_ctr <= stall_ctr + 32'd1;
            end
            // A commit this cycle forces the flag low next cycle.
            hang_r <= !commit_v && (stall_ctr >= 32'(STALL_THRESHOLD));
        end
    end

    assign hang = hang_r;
`else
    assign hang = 1'b0;
`endif

endmodule

// File: doc/commit_trace_tx.md
# commit_trace_tx

Synthesizable commit-trace transmitter inside `core_top`, driven by the ROB commit stream. Every architectural commit becomes a timestamped, sequence-numbered trace record in a small FIFO, sent over a valid/ready port to an external consumer (bench monitor or debug bridge). Also keeps the cycle, commit and drop counters and an optional no-commit watchdog, so benches no longer need hierarchical peeks for these.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2.
- `PREG_W`, 6, physical register index width.
- `STALL_THRESHOLD`, 200, cycles without a commit before `hang` asserts.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `commit_v`  in  1  ROB commit strobe; one commit per cycle maximum.
- `commit_pc`  in  32  PC of the committing instruction.
- `commit_rd_used`  in  1  committing instruction writes rd.
- `commit_rd`  in  5  architectural destination register.
- `commit_prd`  in  PREG_W  physical destination register.
- `commit_data`  in  32  value written to `commit_prd`; don't-care when `commit_rd_used`=0.
- `tr_valid`  out  1  trace record available.
- `tr_ready`  in  1  consumer accepts the record.
- `tr_seq`  out  32  commit sequence number, 0-based.
- `tr_cycle`  out  32  `cycle_count` value in the commit cycle.
- `tr_pc`, `tr_rd`, `tr_rd_used`, `tr_prd`, `tr_data`  out  32/5/1/PREG_W/32  captured commit fields.
- `cycle_count`  out  32  cycles since reset release.
- `commit_count`  out  32  total commits, including dropped ones.
- `drop_count`  out  16  records lost to FIFO full; saturates at 0xFFFF.
- `overflow`  out  1  sticky; set on the first drop.
- `hang`  out  1  watchdog flag.

## Operation
- **Push:** on `commit_v`, the record {`commit_count`, `cycle_count`, pc, rd, rd_used, prd, data} is written at the FIFO tail.
  - With `commit_rd_used`=0, or `commit_rd`=0, the stored `tr_data` is 0.
- **Pop:** a handshake (`tr_valid` & `tr_ready`) pops the FIFO head. `tr_*` outputs are driven from the head entry.
- **Pointers:** head and tail pointers are log2(DEPTH)+1 bits wide and wrap naturally. Full and empty are decided by comparing the MSBs of the two pointers.
- **Full:**
  - A push while full and not popping is dropped.
  - On a drop, `drop_count` increments (saturating) and `overflow` sets.
  - `commit_count` still increments on a drop.
- **Full with a same-cycle pop:** the push is accepted and the occupancy is unchanged.
- **Empty with a same-cycle push:** the record appears the next cycle; there is no combinational bypass.
- **Counters:**
  - `cycle_count` increments every cycle with `rst`=0 and wraps at 2^32.
  - `commit_count` increments per `commit_v` and wraps at 2^32.
- **Watchdog:**
  - `stall_ctr` (32-bit, saturating) clears on `commit_v` and otherwise increments.
  - `hang` is registered, equal to (`stall_ctr` ≥ STALL_THRESHOLD).
  - `hang` clears the cycle after a commit.
- **`tr_*` holding:** `tr_*` stays stable while `tr_valid`=1 and `tr_ready`=0.

## Timing
- **Reset:**
  - The FIFO is emptied.
  - `tr_valid`=0, all `tr_*` fields=0, all counters=0, `overflow`=0, `hang`=0, `stall_ctr`=0.
  - A `commit_v` in a reset cycle is ignored.
- **Reset mid-operation:** all queued records are discarded. The first cycle after reset has `cycle_count`=0.
- **Latency:** `commit_v` at edge N gives `tr_valid`=1 after edge N (cycle N+1) when the FIFO was empty.
- **Throughput:** one record per cycle in and out.
- **Backpressure:** `tr_ready` may be held low indefinitely. There is no loss until DEPTH records are queued.
- **Watchdog timing:** with no commits from reset, `hang` rises in cycle STALL_THRESHOLD+1.

## Configuration
- **`OOOP_TRACE_WATCHDOG_EN` defined:** `stall_ctr` and `hang` are built as described above.
- **`OOOP_TRACE_WATCHDOG_EN` undefined:** no watchdog logic is built, `hang` is tied to 0, and `STALL_THRESHOLD` is unused. All other behaviour is identical.

## Test plan
- **Single commit:**
  - Stimulus: reset, wait 3 cycles, then one commit (pc=0x100, rd=10, data=0x2A, rd_used=1), `tr_ready`=1.
  - Expected: one record with seq=0, cycle=3, pc=0x100, data=0x2A, valid for exactly 1 cycle.
- **Backpressure:**
  - Stimulus: `tr_ready`=0, 8 back-to-back commits, then `tr_ready`=1.
  - Expected: seq 0..7 delivered in order over 8 consecutive cycles; `drop_count`=0, `overflow`=0.
- **Overflow:**
  - Stimulus: `tr_ready`=0, 10 back-to-back commits.
  - Expected: `drop_count`=2, `overflow`=1, `commit_count`=10; the drained records are seq 0..7.
- **Full with simultaneous push and pop:**
  - Stimulus: FIFO full (8 entries), `tr_ready`=1 and `commit_v`=1 for 4 cycles.
  - Expected: no drops; occupancy stays 8; sequence numbers are contiguous.
- **Watchdog (`OOOP_TRACE_WATCHDOG_EN` defined), `STALL_THRESHOLD`=5:**
  - Stimulus: no commits from reset, then one commit.
  - Expected: `hang`=1 in cycle 6; `hang`=0 the cycle after the commit. With the macro undefined, `hang` is always 0.
- **Reset mid-stream:**
  - Stimulus: 4 records queued, then a 1-cycle `rst`.
  - Expected: `tr_valid`=0, all counters 0; the next commit has seq=0.
